// File: rtl/phy_tx_arbiter.sv
// Link trainer plus two-way round-robin burst arbiter feeding the phy_tx word input.
// Optional per-requester transfer counters are enabled by defining PHY_TX_ARBITER_STATS_EN.
module phy_tx_arbiter #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  INIT_WORDS = 4,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 32'hBCBCBCBC,
    parameter int                  MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    input  logic                  valid_in_0,
    output logic                  ready_0,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic                  valid_in_1,
    output logic                  ready_1,
    output logic [DATA_WIDTH-1:0] data_in_tx,
    output logic                  valid_in_tx,
    output logic                  link_up,
    output logic                  grant_id
`ifdef PHY_TX_ARBITER_STATS_EN
    ,
    output logic [15:0]           words_sent_0,
    output logic [15:0]           words_sent_1
`endif
);

    localparam int TRAIN_W = $clog2(INIT_WORDS + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(INIT_WORDS - 1);
    localparam logic [TRAIN_W-1:0] TRAIN_SAT  = TRAIN_W'(INIT_WORDS);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {TRAIN, IDLE, GRANT0, GRANT1} state_t;

    state_t               state, next_state;
    logic [TRAIN_W-1:0]   train_cnt;
    logic [BURST_W-1:0]   burst_cnt;
    logic                 rr_ptr;
    logic                 xfer;
    logic [DATA_WIDTH-1:0] xfer_data;
    logic                 grant_set;
    logic                 grant_next;
    logic                 own_valid;
    logic                 other_valid;
    logic                 own_id;

    assign ready_0 = (state == GRANT0);
    assign ready_1 = (state == GRANT1);

    always_comb begin
        next_state  = state;
        grant_set   = 1'b0;
        grant_next  = grant_id;
        own_id      = (state == GRANT1);
        own_valid   = own_id ? valid_in_1 : valid_in_0;
        other_valid = own_id ? valid_in_0 : valid_in_1;
        xfer        = (ready_0 & valid_in_0) | (ready_1 & valid_in_1);
        xfer_data   = own_id ? data_in_1 : data_in_0;
        case (state)
            TRAIN: begin
                if (train_cnt == TRAIN_LAST) next_state = IDLE;
            end
            IDLE: begin
                if (valid_in_0 || valid_in_1) begin
                    grant_set = 1'b1;
                    // On a tie the requester that did not own the last grant wins.
                    if (valid_in_0 && valid_in_1) grant_next = ~rr_ptr;
                    else                          grant_next = valid_in_1;
                    next_state = grant_next ? GRANT1 : GRANT0;
                end
            end
            default: begin
                if (!own_valid || burst_cnt == BURST_LAST) begin
                    if (other_valid) begin
                        grant_set  = 1'b1;
                        grant_next = ~own_id;
                        next_state = grant_next ? GRANT1 : GRANT0;
                    end else if (own_valid) begin
                        grant_set  = 1'b1;
                        grant_next = own_id;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= TRAIN;
            train_cnt   <= '0;
            burst_cnt   <= '0;
            data_in_tx  <= IDLE_WORD;
            valid_in_tx <= 1'b0;
            link_up     <= 1'b0;
            grant_id    <= 1'b0;
            rr_ptr      <= 1'b1;
        end else begin
            state <= next_state;
            if (state == TRAIN && train_cnt != TRAIN_SAT) train_cnt <= train_cnt + 1'b1;
            // Delayed by one so link_up rises together with the first idle word.
            link_up <= (state != TRAIN);
            if (state == TRAIN) begin
                data_in_tx  <= IDLE_WORD;
                valid_in_tx <= 1'b1;
            end else if (xfer) begin
                data_in_tx  <= xfer_data;
                valid_in_tx <= 1'b1;
            end else begin
                data_in_tx  <= IDLE_WORD;
                valid_in_tx <= 1'b0;
            end
            if (grant_set)  burst_cnt <= '0;
            else if (xfer)  burst_cnt <= burst_cnt + 1'b1;
            if (grant_set) begin
                grant_id <= grant_next;
                rr_ptr   <= grant_next;
            end
        end
    end

`ifdef PHY_TX_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            words_sent_0 <= '0;
            words_sent_1 <= '0;
        end else begin
            if (ready_0 && valid_in_0) words_sent_0 <= words_sent_0 + 16'd1;
            if (ready_1 && valid_in_1) words_sent_1 <= words_sent_1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Directed bench for phy_tx_arbiter: training, single bursts, alternation,
// burst splitting and mid-burst reset, with hand-computed expectations.
module tb_phy_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in_0, data_in_1;
    logic        valid_in_0, valid_in_1;
    logic        ready_0, ready_1;
    logic [31:0] data_in_tx;
    logic        valid_in_tx, link_up, grant_id;
`ifdef PHY_TX_ARBITER_STATS_EN
    logic [15:0] words_sent_0, words_sent_1;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IW = 32'hBCBCBCBC;

    phy_tx_arbiter dut (
        .clk(clk), .reset(reset),
        .data_in_0(data_in_0), .valid_in_0(valid_in_0), .ready_0(ready_0),
        .data_in_1(data_in_1), .valid_in_1(valid_in_1), .ready_1(ready_1),
        .data_in_tx(data_in_tx), .valid_in_tx(valid_in_tx),
        .link_up(link_up), .grant_id(grant_id)
`ifdef PHY_TX_ARBITER_STATS_EN
        , .words_sent_0(words_sent_0), .words_sent_1(words_sent_1)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] d, input logic v,
                             input logic l, input logic g);
        check({tag, ".data"}, data_in_tx, d);
        check({tag, ".valid"}, {31'd0, valid_in_tx}, {31'd0, v});
        check({tag, ".link"}, {31'd0, link_up}, {31'd0, l});
        check({tag, ".grant"}, {31'd0, grant_id}, {31'd0, g});
    endtask

    // Alternating 4-word bursts, requester 1 first (requester 0 owned the previous grant).
    logic [31:0] exp3 [16] = '{
        32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004,
        32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004,
        32'hB0000005, 32'hB0000006, 32'hB0000007, 32'hB0000008,
        32'hA0000005, 32'hA0000006, 32'hA0000007, 32'hA0000008};
    logic [31:0] words2 [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    logic        exp3_grant [16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int n0, n1;
        logic acc0, acc1;
        reset = 1'b1; valid_in_0 = 1'b0; valid_in_1 = 1'b0;
        data_in_0 = '0; data_in_1 = '0;

        // Reset for two cycles, then training.
        tick(); tick();
        check_out("rst", IW, 1'b0, 1'b0, 1'b0);
        check("rst.ready_0", {31'd0, ready_0}, 32'd0);
        check("rst.ready_1", {31'd0, ready_1}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("train%0d", i), IW, 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_out("link", IW, 1'b0, 1'b1, 1'b0);
        check("link.ready_0", {31'd0, ready_0}, 32'd0);

        // Requester 0 alone, three words.
        valid_in_0 = 1'b1; data_in_0 = words2[0];
        tick();
        check_out("s2.grant", IW, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            data_in_0 = words2[i];
            check($sformatf("s2.ready_0_%0d", i), {31'd0, ready_0}, 32'd1);
            check($sformatf("s2.ready_1_%0d", i), {31'd0, ready_1}, 32'd0);
            tick();
            check_out($sformatf("s2.w%0d", i), words2[i], 1'b1, 1'b1, 1'b0);
        end
        valid_in_0 = 1'b0;
        tick();
        check_out("s2.idle", IW, 1'b0, 1'b1, 1'b0);
        check("s2.idle.ready_0", {31'd0, ready_0}, 32'd0);

        // Both requesters continuously valid.
        n0 = 0; n1 = 0;
        valid_in_0 = 1'b1; valid_in_1 = 1'b1;
        data_in_0 = 32'hA0000001; data_in_1 = 32'hB0000001;
        tick();
        check_out("s3.grant", IW, 1'b0, 1'b1, 1'b1);
        check("s3.ready_1", {31'd0, ready_1}, 32'd1);
        for (int k = 0; k < 16; k++) begin
            acc0 = ready_0; acc1 = ready_1;
            check($sformatf("s3.excl%0d", k), {31'd0, ready_0 & ready_1}, 32'd0);
            tick();
            if (acc0) n0++;
            if (acc1) n1++;
            data_in_0 = 32'hA0000001 + n0;
            data_in_1 = 32'hB0000001 + n1;
            check_out($sformatf("s3.w%0d", k), exp3[k], 1'b1, 1'b1, exp3_grant[k]);
        end
`ifdef PHY_TX_ARBITER_STATS_EN
        // Requester 0 also sent three words earlier.
        check("s3.words_sent_0", {16'd0, words_sent_0}, 32'd11);
        check("s3.words_sent_1", {16'd0, words_sent_1}, 32'd8);
`endif
        valid_in_0 = 1'b0; valid_in_1 = 1'b0;
        tick();
        check_out("s3.idle", IW, 1'b0, 1'b1, 1'b1);

        // Requester 1 alone for ten words: bursts of 4, 4, 2 with no gaps.
        n1 = 0;
        valid_in_1 = 1'b1; data_in_1 = 32'hC0000001;
        tick();
        check_out("s4.grant", IW, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("s4.ready_1_%0d", k), {31'd0, ready_1}, 32'd1);
            check($sformatf("s4.ready_0_%0d", k), {31'd0, ready_0}, 32'd0);
            tick();
            check_out($sformatf("s4.w%0d", k), 32'hC0000001 + k, 1'b1, 1'b1, 1'b1);
            data_in_1 = 32'hC0000002 + k;
        end

        // One more word into the third burst, then reset mid-burst.
        data_in_1 = 32'hD0000001;
        tick();
        check_out("s5.w", 32'hD0000001, 1'b1, 1'b1, 1'b1);
        reset = 1'b1; data_in_1 = 32'hD0000002;
        tick();
        check_out("s5.rst", IW, 1'b0, 1'b0, 1'b0);
        check("s5.rst.ready_1", {31'd0, ready_1}, 32'd0);
`ifdef PHY_TX_ARBITER_STATS_EN
        check("s5.words_sent_0", {16'd0, words_sent_0}, 32'd0);
        check("s5.words_sent_1", {16'd0, words_sent_1}, 32'd0);
`endif
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("s5.train%0d", i), IW, 1'b1, 1'b0, 1'b0);
            check($sformatf("s5.train%0d.ready_1", i), {31'd0, ready_1}, 32'd0);
        end
        tick();
        check_out("s5.link", IW, 1'b0, 1'b1, 1'b1);
        check("s5.link.ready_1", {31'd0, ready_1}, 32'd1);
        tick();
        check_out("s5.w2", 32'hD0000002, 1'b1, 1'b1, 1'b1);
        valid_in_1 = 1'b0;
        tick();
        check_out("s5.idle", IW, 1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
